// File: rtl/bitonic_frame_packer.sv
// -----------------------------------------------------------------------------
// bitonic_frame_packer
//   Upstream writer for bitonic_sort. Keys arrive one per cycle on a
//   valid/ready stream. The packer collects N of them into a fill buffer and
//   moves each completed frame into a held output register. While a finished
//   frame waits in that register, the next frame keeps filling, so back-to-back
//   frames run without bubbles. Only the key that would complete a frame is
//   ever stalled.
//
//   Optional feature macro: PACK_FLUSH_EN
//     defined   - flush closes a partial frame and pads the unfilled slots
//                 with PAD_VALUE.
//     undefined - the flush input is present but ignored.
//
// Ports
//   clk        in   1              clock, all logic on posedge
//   reset      in   1              synchronous, active-high
//   in_data    in   INPUT_WIDTH    key to append
//   in_valid   in   1              in_data valid
//   in_ready   out  1              key accepted when in_valid && in_ready
//   flush      in   1              close the partial frame (PACK_FLUSH_EN only)
//   out        out  N*INPUT_WIDTH  packed frame; slot k = out[k*W +: W],
//                                  so slot 0 occupies the MSBs
//   out_valid  out  1              frame in out is valid
//   out_ready  in   1              frame consumed when out_valid && out_ready
// -----------------------------------------------------------------------------
module bitonic_frame_packer #(
   parameter int                     N           = 8,
   parameter int                     INPUT_WIDTH = 4,
   parameter int                     log_N       = $clog2(N),
   parameter logic [INPUT_WIDTH-1:0] PAD_VALUE   = {INPUT_WIDTH{1'b1}}
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [INPUT_WIDTH-1:0]     in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       flush,
   output logic [0:N*INPUT_WIDTH-1]   out,
   output logic                       out_valid,
   input  logic                       out_ready
);

   localparam logic [log_N-1:0] LAST_SLOT = log_N'(N - 1);

   logic [log_N-1:0]         count_q;
   logic [INPUT_WIDTH-1:0]   fill_q [N];
   logic [0:N*INPUT_WIDTH-1] out_q;
   logic                     out_valid_q;
   logic [0:N*INPUT_WIDTH-1] frame_d;

   logic free;
   logic accept;
   logic complete;
   logic do_flush;
   logic emit;

   // Output register can take a new frame if it is empty or drained this cycle.
   assign free     = !out_valid_q || out_ready;
   assign in_ready = !reset && !((count_q == LAST_SLOT) && !free);
   assign accept   = in_valid && in_ready;
   assign complete = accept && (count_q == LAST_SLOT);

`ifdef PACK_FLUSH_EN
   // A key accepted alongside flush lands first; if it completes the frame the
   // flush has nothing left to do. An empty frame is never emitted.
   assign do_flush = flush && free && !complete && ((count_q != '0) || accept);
`else
   logic unused_flush;
   assign unused_flush = flush;
   assign do_flush     = 1'b0;
`endif

   assign emit = complete || do_flush;

   // Outgoing frame: filled slots, then the key accepted this cycle, then pad.
   // For a completing key every slot below it is filled, so pad never shows.
   always_comb begin
      frame_d = '0;
      for (int k = 0; k < N; k++) begin
         if (k < int'(count_q))
            frame_d[k*INPUT_WIDTH +: INPUT_WIDTH] = fill_q[k];
         else if ((k == int'(count_q)) && accept)
            frame_d[k*INPUT_WIDTH +: INPUT_WIDTH] = in_data;
         else
            frame_d[k*INPUT_WIDTH +: INPUT_WIDTH] = PAD_VALUE;
      end
   end

   // Stage boundary: fill buffer, slot counter and output register.
   // The fill buffer is not cleared between frames; slots at or above count_q
   // are always overwritten or padded before they can be emitted.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q     <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         for (int k = 0; k < N; k++) fill_q[k] <= '0;
      end else if (emit) begin
         out_q       <= frame_d;
         out_valid_q <= 1'b1;
         count_q     <= '0;
      end else begin
         if (accept) begin
            fill_q[count_q] <= in_data;
            count_q         <= count_q + 1'b1;
         end
         if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bitonic_frame_packer.sv
module tb_bitonic_frame_packer;

   localparam int N = 8;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [W-1:0]   in_data;
   logic           in_valid;
   logic           in_ready;
   logic           flush;
   logic [0:N*W-1] out;
   logic           out_valid;
   logic           out_ready;

   int total  = 0;
   int passed = 0;

   bitonic_frame_packer #(.N(N), .INPUT_WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .flush    (flush),
      .out      (out),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // Advance one clock; sampling and driving happen 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Present one key and clock it in (no readiness check here).
   task automatic send(input logic [W-1:0] k);
      in_data  = k;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   logic [W-1:0] keys1 [8] = '{4'h0, 4'h9, 4'h2, 4'h3, 4'h5, 4'h8, 4'hf, 4'h4};
   int stalls;

   initial begin
      reset = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      tick(); tick();

      // Reset state
      in_valid = 1'b1;
      #1;
      check("reset_in_ready", 64'(in_ready), 64'd0);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out", 64'(out), 64'd0);
      in_valid = 1'b0;
      reset = 1'b0;
      #1;
      check("idle_in_ready", 64'(in_ready), 64'd1);

      // Single frame 0,9,2,3,5,8,f,4
      for (int i = 0; i < 8; i++) begin
         send(keys1[i]);
         if (i == 6) check("f1_not_early", 64'(out_valid), 64'd0);
      end
      check("f1_valid", 64'(out_valid), 64'd1);
      check("f1_data", 64'(out), 64'h0923_58f4);
      tick();
      check("f1_valid_one_cycle", 64'(out_valid), 64'd0);

      // 16 keys back-to-back, no bubble
      stalls = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_data = W'(i);
         #1;
         if (!in_ready) stalls++;
         tick();
         if (i == 7) begin
            check("b2b_f1_valid", 64'(out_valid), 64'd1);
            check("b2b_f1_data", 64'(out), 64'h0123_4567);
         end
         if (i == 8) check("b2b_gap_valid", 64'(out_valid), 64'd0);
         if (i == 15) begin
            check("b2b_f2_valid", 64'(out_valid), 64'd1);
            check("b2b_f2_data", 64'(out), 64'h89ab_cdef);
         end
      end
      in_valid = 1'b0;
      check("b2b_no_stall", 64'(stalls), 64'd0);
      tick();

      // Backpressure: frame 1 held, 8th key of frame 2 stalls
      send(4'ha); send(4'hb); send(4'hc); send(4'hd);
      send(4'he); send(4'hf); send(4'h0); send(4'h1);
      out_ready = 1'b0;
      check("bp_f1_data", 64'(out), 64'habcd_ef01);
      stalls = 0;
      for (int i = 2; i < 9; i++) begin
         in_data = W'(i); in_valid = 1'b1;
         #1;
         if (!in_ready) stalls++;
         tick();
      end
      check("bp_7_accepted", 64'(stalls), 64'd0);
      in_data = 4'h9; in_valid = 1'b1;
      #1;
      check("bp_8th_stalled", 64'(in_ready), 64'd0);
      tick();
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_data", 64'(out), 64'habcd_ef01);
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("bp_f2_valid", 64'(out_valid), 64'd1);
      check("bp_f2_data", 64'(out), 64'h2345_6789);
      tick();
      check("bp_drain", 64'(out_valid), 64'd0);

      // Reset mid-frame, including a pending frame
      for (int i = 0; i < 8; i++) send(4'h7);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(4'hf);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      check("rst_mid_valid", 64'(out_valid), 64'd0);
      check("rst_mid_out", 64'(out), 64'd0);
      for (int i = 0; i < 8; i++) send(W'(i));
      check("rst_after_valid", 64'(out_valid), 64'd1);
      check("rst_after_data", 64'(out), 64'h0123_4567);
      tick();

`ifdef PACK_FLUSH_EN
      // Partial frame padded on flush
      send(4'h1); send(4'h2); send(4'h3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_valid", 64'(out_valid), 64'd1);
      check("flush_data", 64'(out), 64'h123f_ffff);
      tick();
      check("flush_drain", 64'(out_valid), 64'd0);
      // Flush with nothing collected
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_empty", 64'(out_valid), 64'd0);
      // Flush with the completing key
      for (int i = 0; i < 7; i++) send(W'(i));
      in_data = 4'h7; in_valid = 1'b1; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      check("flush_full_valid", 64'(out_valid), 64'd1);
      check("flush_full_data", 64'(out), 64'h0123_4567);
      tick();
      check("flush_full_no_extra", 64'(out_valid), 64'd0);
`else
      // Flush ignored: partial frame keeps filling
      send(4'h1); send(4'h2); send(4'h3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("noflush_no_valid", 64'(out_valid), 64'd0);
      send(4'h4); send(4'h5); send(4'h6); send(4'h7);
      check("noflush_not_early", 64'(out_valid), 64'd0);
      send(4'h8);
      check("noflush_valid", 64'(out_valid), 64'd1);
      check("noflush_data", 64'(out), 64'h1234_5678);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
